ram8: RTL and testbench

Eight-word, 16-bit addressable memory: the storage stage that consumes the one-hot load strobes produced by the demultiplexer tree and drives a multiplexed read port. One-hot load decoding selects a row, per-row registers hold the data, and an 8-way read mux returns the addressed word. It is the base tile from which the larger RAM blocks are composed.

---
 rtl/ram_pkg.sv | 19 +
 rtl/ram8_if.sv | 40 ++++
 rtl/register16.sv | 48 ++++
 rtl/ram8.sv | 49 ++++
 tb/tb_ram8.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Purpose  : Shared constants for the RAM tile family. The 8-word tile and
//            the larger tiles composed from it take word width, address
//            width and depth from here, so they stay consistent.
// Contents : WORD_W      - word width in bits
//            RAM8_ADDR_W - address width of the 8-word tile
//            RAM8_DEPTH  - number of words in the 8-word tile
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

  localparam int WORD_W      = 16;
  localparam int RAM8_ADDR_W = 3;
  localparam int RAM8_DEPTH  = 8;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram8_if.sv
`default_nettype none
// ============================================================================
// Module   : ram8_if
// Purpose  : Bus bundle for the 8-word RAM tile: write data, write enable,
//            shared read/write address and combinational read data.
// Signals  : in      - write data, WIDTH bits          (master -> slave)
//            load    - write enable                    (master -> slave)
//            address - word select for read and write  (master -> slave)
//            out     - contents of word[address]       (slave -> master)
// Modports : master - the client driving the tile
//            slave  - the RAM tile itself
// Revision : 1.0 - initial release
// ============================================================================
interface ram8_if
  import ram_pkg::*;
#(
  parameter int WIDTH = WORD_W
);

  logic [WIDTH-1:0]       in;
  logic                   load;
  logic [RAM8_ADDR_W-1:0] address;
  logic [WIDTH-1:0]       out;

  modport master (
    output in,
    output load,
    output address,
    input  out
  );

  modport slave (
    input  in,
    input  load,
    input  address,
    output out
  );

endinterface : ram8_if
`default_nettype wire

// File: rtl/register16.sv
`default_nettype none
// ============================================================================
// Module   : register16
// Purpose  : WIDTH-bit register with load enable and asynchronous
//            active-low clear. One row of the RAM tile.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low clear to 0
//            in    - data captured when load is high
//            load  - load enable, sampled at the rising edge of clk
//            out   - registered value
// Revision : 1.0 - initial release
// ============================================================================
module register16
  import ram_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] in,
  input  wire logic             load,
  output logic      [WIDTH-1:0] out
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = in;
    end
  end

  // A reset edge arriving in the same timestep as a load edge always lands
  // on 0: whichever event is scheduled last sees rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign out = word_q;

endmodule : register16
`default_nettype wire

// File: rtl/ram8.sv
`default_nettype none
// ============================================================================
// Module   : ram8
// Purpose  : Eight-word RAM tile. A one-hot demultiplex of load selects the
//            row to write, eight register16 rows hold the data, and an 8:1
//            mux returns word[address] combinationally.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset, clears every row
//            bus   - ram8_if slave: in, load, address (inputs), out (output)
// Revision : 1.0 - initial release
// ============================================================================
module ram8
  import ram_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  wire logic clk,
  input  wire logic rst_n,
  ram8_if.slave     bus
);

  logic [RAM8_DEPTH-1:0] en;
  logic [WIDTH-1:0]      rows [RAM8_DEPTH];

  generate
    for (genvar i = 0; i < RAM8_DEPTH; i++) begin : g_row
      localparam logic [RAM8_ADDR_W-1:0] ROW_ADDR = RAM8_ADDR_W'(i);

      // One-hot load decode: only the addressed row sees load.
      assign en[i] = bus.load & (bus.address == ROW_ADDR);

      register16 #(
        .WIDTH (WIDTH)
      ) u_row (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (bus.in),
        .load  (en[i]),
        .out   (rows[i])
      );
    end
  endgenerate

  // Purely combinational read; a write shows up only after its clock edge,
  // because the mux reads register outputs rather than bus.in.
  assign bus.out = rows[bus.address];

endmodule : ram8
`default_nettype wire

// File: tb/tb_ram8.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram8
// Purpose  : Directed self-checking bench for the 8-word RAM tile: reset,
//            fill/readback, load-low hold, read-during-write, decode
//            isolation, asynchronous reset mid-cycle and on a write edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  ram8_if #(.WIDTH(16)) bus ();

  ram8 #(
    .WIDTH (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a write at the falling edge; it commits on the next rising edge.
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address = a;
    bus.in      = d;
    bus.load    = 1'b1;
    @(posedge clk);
    #1;
    bus.load    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
    @(negedge clk);
    bus.load    = 1'b0;
    bus.address = a;
    #1;
    check(tag, bus.out, exp);
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    bus.in      = 16'h0000;
    bus.load    = 1'b0;
    bus.address = 3'd0;

    // Reset state
    #2;
    check("reset_addr0", bus.out, 16'h0000);
    bus.address = 3'd5;
    #1;
    check("reset_addr5", bus.out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill on consecutive edges, then sweep with load low
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.address = 3'(i);
      bus.in      = 16'hA500 + 16'(i);
      bus.load    = 1'b1;
      @(negedge clk);
    end
    bus.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd($sformatf("fill_rd%0d", i), 3'(i), 16'hA500 + 16'(i));
    end

    // Load low: sweep address with in = FFFF across 8 edges
    bus.in = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.address = 3'(i);
      @(posedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      rd($sformatf("hold_rd%0d", i), 3'(i), 16'hA500 + 16'(i));
    end

    // Read-during-write on row 3
    wr(3'd3, 16'h1111);
    rd("rdw_pre_val", 3'd3, 16'h1111);
    @(negedge clk);
    bus.address = 3'd3;
    bus.in      = 16'h2222;
    bus.load    = 1'b1;
    #1;
    check("rdw_before_edge", bus.out, 16'h1111);
    @(posedge clk);
    #1;
    check("rdw_after_edge", bus.out, 16'h2222);
    bus.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i != 3) begin
        rd($sformatf("rdw_other%0d", i), 3'(i), 16'hA500 + 16'(i));
      end
    end

    // Back-to-back writes to the same row: each value visible one cycle
    @(negedge clk);
    bus.address = 3'd6;
    bus.in      = 16'h0101;
    bus.load    = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_first", bus.out, 16'h0101);
    @(negedge clk);
    bus.in = 16'h0202;
    @(posedge clk);
    #1;
    check("b2b_second", bus.out, 16'h0202);
    bus.load = 1'b0;

    // Decode isolation: one row at FFFF, the rest at 0
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 16'h0000);
    end
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 16'hFFFF);
      for (int j = 0; j < 8; j++) begin
        rd($sformatf("iso_w%0d_r%0d", i, j), 3'(j), (i == j) ? 16'hFFFF : 16'h0000);
      end
      wr(3'(i), 16'h0000);
    end

    // Mid-cycle reset after writes; load held high is ignored while low
    wr(3'd2, 16'h1357);
    wr(3'd7, 16'h2468);
    rd("prereset_r2", 3'd2, 16'h1357);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear_now", bus.out, 16'h0000);
    bus.address = 3'd2;
    bus.in      = 16'hFFFF;
    bus.load    = 1'b1;
    @(posedge clk);
    #1;
    check("load_ignored_in_reset", bus.out, 16'h0000);
    bus.load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd($sformatf("post_reset%0d", i), 3'(i), 16'h0000);
    end

    // Reset falling on the same edge as a write to row 5
    wr(3'd5, 16'h1234);
    wr(3'd4, 16'h4321);
    rd("edge_pre_r5", 3'd5, 16'h1234);
    @(negedge clk);
    bus.address = 3'd5;
    bus.in      = 16'hBEEF;
    bus.load    = 1'b1;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("edge_reset_now", bus.out, 16'h0000);
    bus.load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd("edge_reset_r5", 3'd5, 16'h0000);
    rd("edge_reset_r4", 3'd4, 16'h0000);

    // First write after release lands on the first rising edge
    wr(3'd1, 16'hC0DE);
    rd("post_release_wr", 3'd1, 16'hC0DE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ram8
`default_nettype wire
